// File: rtl/contador_programa_pkg.sv
// pkg_procesador: shared widths, reset defaults and PC-stage state encoding.
// Rev 1.0
`default_nettype none

package pkg_procesador;

  localparam int              ANCHO_DEF      = 64;
  localparam logic [63:0]     RESET_PC_DEF   = 64'h0;
  localparam int              INCREMENTO_DEF = 4;

  typedef enum logic [1:0] {
    INICIO   = 2'b00,
    PEDIR    = 2'b01,
    DETENIDO = 2'b10
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/sumador_pc.sv
// sumador_pc: sequential-fetch adder, wraps modulo 2^ANCHO.
// Rev 1.0
`default_nettype none

module sumador_pc #(
  parameter int ANCHO      = 64,
  parameter int INCREMENTO = 4
) (
  input  logic [ANCHO-1:0] pc,
  output logic [ANCHO-1:0] pc_siguiente
);

  assign pc_siguiente = pc + ANCHO'(INCREMENTO);

endmodule

`default_nettype wire

// File: rtl/contador_programa.sv
// contador_programa: PC register and instruction-fetch request FSM with branch redirect.
// Rev 1.0
`default_nettype none

module contador_programa
  import pkg_procesador::*;
#(
  parameter int               ANCHO      = ANCHO_DEF,
  parameter logic [ANCHO-1:0] RESET_PC   = ANCHO'(RESET_PC_DEF),
  parameter int               INCREMENTO = INCREMENTO_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ANCHO-1:0] result_suma,
  input  logic             salto,
  input  logic             stall,
  input  logic             im_ready,
  output logic [ANCHO-1:0] bus_direccion_im,
  output logic             im_req,
  output logic             instr_valida,
  output logic [ANCHO-1:0] pc_instr
);

  estado_t          estado, estado_sig;
  logic [ANCHO-1:0] pc_sig, pc_mas;
  logic [ANCHO-1:0] destino, destino_sig;
  logic             pendiente, pendiente_sig;
  logic             valida_sig;
  logic [ANCHO-1:0] pc_instr_sig;
  logic [ANCHO-1:0] objetivo;

  sumador_pc #(
    .ANCHO      (ANCHO),
    .INCREMENTO (INCREMENTO)
  ) u_sumador (
    .pc           (bus_direccion_im),
    .pc_siguiente (pc_mas)
  );

  // Branch targets are word aligned; low two bits are dropped.
  assign objetivo = result_suma & ~ANCHO'(3);

  assign im_req = (estado == PEDIR);

  always_comb begin
    estado_sig    = estado;
    pc_sig        = bus_direccion_im;
    destino_sig   = destino;
    pendiente_sig = pendiente;
    valida_sig    = 1'b0;
    pc_instr_sig  = pc_instr;
    case (estado)
      INICIO: begin
        if (salto) pc_sig = objetivo;
        estado_sig = stall ? DETENIDO : PEDIR;
      end
      PEDIR: begin
        if (im_ready) begin
          if (salto)          pc_sig = objetivo;
          else if (pendiente) pc_sig = destino;
          else                pc_sig = pc_mas;
          pendiente_sig = 1'b0;
          valida_sig    = !salto && !pendiente;
          pc_instr_sig  = bus_direccion_im;
          estado_sig    = stall ? DETENIDO : PEDIR;
        end else if (salto) begin
          // Address must stay stable until accepted; remember the redirect.
          pendiente_sig = 1'b1;
          destino_sig   = objetivo;
        end
      end
      DETENIDO: begin
        if (salto)  pc_sig     = objetivo;
        if (!stall) estado_sig = PEDIR;
      end
      default: estado_sig = INICIO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado           <= INICIO;
      bus_direccion_im <= RESET_PC;
      destino          <= '0;
      pendiente        <= 1'b0;
      instr_valida     <= 1'b0;
      pc_instr         <= '0;
    end else begin
      estado           <= estado_sig;
      bus_direccion_im <= pc_sig;
      destino          <= destino_sig;
      pendiente        <= pendiente_sig;
      instr_valida     <= valida_sig;
      pc_instr         <= pc_instr_sig;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_contador_programa.sv
// tb_contador_programa: scoreboard bench for the PC / fetch-address stage.
// Rev 1.0
`default_nettype none

module tb_contador_programa;

  logic        clk = 1'b0;
  logic        reset_n, reset_n_w;
  logic [63:0] result_suma;
  logic        salto, stall, im_ready, im_ready_w;
  logic [63:0] bus, bus_w, pc_instr, pc_instr_w;
  logic        im_req, im_req_w, instr_valida, instr_valida_w;

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [63:0] q_w[$];

  always #5 clk = ~clk;

  contador_programa dut (
    .clk(clk), .reset_n(reset_n), .result_suma(result_suma), .salto(salto),
    .stall(stall), .im_ready(im_ready), .bus_direccion_im(bus), .im_req(im_req),
    .instr_valida(instr_valida), .pc_instr(pc_instr)
  );

  contador_programa #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
    .clk(clk), .reset_n(reset_n_w), .result_suma(result_suma), .salto(salto),
    .stall(stall), .im_ready(im_ready_w), .bus_direccion_im(bus_w), .im_req(im_req_w),
    .instr_valida(instr_valida_w), .pc_instr(pc_instr_w)
  );

  // Scoreboard: every instr_valida pulse must match the oldest expected fetch.
  always @(negedge clk) begin
    logic [63:0] e;
    if (instr_valida) begin
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL sb_unexpected pc_instr=%h required=none", pc_instr);
      end else begin
        e = q.pop_front();
        if (pc_instr !== e) begin
          errors++; $display("FAIL sb_pc_instr got=%h required=%h", pc_instr, e);
        end
      end
    end
    if (instr_valida_w) begin
      checks++;
      if (q_w.size() == 0) begin
        errors++; $display("FAIL sbw_unexpected pc_instr=%h required=none", pc_instr_w);
      end else begin
        e = q_w.pop_front();
        if (pc_instr_w !== e) begin
          errors++; $display("FAIL sbw_pc_instr got=%h required=%h", pc_instr_w, e);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cycle();
    checks++;
    if (bus !== 64'h0 || im_req !== 1'b0 || instr_valida !== 1'b0 || pc_instr !== 64'h0) begin
      errors++;
      $display("FAIL reset_values bus=%h req=%b val=%b pci=%h required=0/0/0/0",
               bus, im_req, instr_valida, pc_instr);
    end
    reset_n = 1'b1;
    cycle();
    checks++;
    if (im_req !== 1'b1 || bus !== 64'h0) begin
      errors++; $display("FAIL first_req req=%b bus=%h required=1/0", im_req, bus);
    end
    cycle();
    // Reset while a request is outstanding.
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (im_req !== 1'b0 || bus !== 64'h0) begin
      errors++; $display("FAIL async_reset req=%b bus=%h required=0/0", im_req, bus);
    end
    cycle();
    reset_n  = 1'b1;
    im_ready = 1'b1;
    checks++;
    if (im_req !== 1'b0) begin
      errors++; $display("FAIL inicio_req got=%b required=0", im_req);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (im_req !== 1'b1 || bus !== 64'(i * 4)) begin
        errors++; $display("FAIL seq_fetch req=%b bus=%h required=1/%h", im_req, bus, 64'(i * 4));
      end
      q.push_back(64'(i * 4));
    end
    cycle();
    im_ready = 1'b0;
    checks++;
    if (bus !== 64'hC) begin
      errors++; $display("FAIL seq_after bus=%h required=c", bus);
    end
  endtask

  task automatic test_backpressure();
    im_ready = 1'b1; q.push_back(64'hC);
    cycle();
    im_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (bus !== 64'h10 || im_req !== 1'b1) begin
        errors++; $display("FAIL bp_hold bus=%h req=%b required=10/1", bus, im_req);
      end
    end
    im_ready = 1'b1; q.push_back(64'h10);
    cycle();
    im_ready = 1'b0;
    checks++;
    if (bus !== 64'h14) begin
      errors++; $display("FAIL bp_next bus=%h required=14", bus);
    end
  endtask

  task automatic test_branch_wait();
    for (int a = 'h14; a < 'h20; a += 4) begin
      im_ready = 1'b1; q.push_back(64'(a));
      cycle();
    end
    im_ready = 1'b0;
    cycle();
    salto = 1'b1; result_suma = 64'h100;
    cycle();
    salto = 1'b0;
    checks++;
    if (bus !== 64'h20 || im_req !== 1'b1) begin
      errors++; $display("FAIL bw_hold bus=%h req=%b required=20/1", bus, im_req);
    end
    cycle();
    im_ready = 1'b1;
    cycle();
    im_ready = 1'b0;
    checks++;
    if (bus !== 64'h100 || instr_valida !== 1'b0) begin
      errors++; $display("FAIL bw_redirect bus=%h val=%b required=100/0", bus, instr_valida);
    end
  endtask

  task automatic test_branch_transfer();
    // Two branches while waiting: the newer one wins, low bits masked.
    salto = 1'b1; result_suma = 64'h500;
    cycle();
    result_suma = 64'h41;
    cycle();
    salto = 1'b0;
    im_ready = 1'b1;
    cycle();
    im_ready = 1'b0;
    checks++;
    if (bus !== 64'h40 || instr_valida !== 1'b0) begin
      errors++; $display("FAIL newest_wins bus=%h val=%b required=40/0", bus, instr_valida);
    end
    im_ready = 1'b1; salto = 1'b1; result_suma = 64'h203;
    cycle();
    salto = 1'b0; im_ready = 1'b0;
    checks++;
    if (bus !== 64'h200 || instr_valida !== 1'b0) begin
      errors++; $display("FAIL bt_redirect bus=%h val=%b required=200/0", bus, instr_valida);
    end
    im_ready = 1'b1; q.push_back(64'h200);
    cycle();
    im_ready = 1'b0;
    checks++;
    if (bus !== 64'h204) begin
      errors++; $display("FAIL bt_next bus=%h required=204", bus);
    end
  endtask

  task automatic test_stall();
    salto = 1'b1; result_suma = 64'h50;
    cycle();
    salto = 1'b0; im_ready = 1'b1;
    cycle();
    im_ready = 1'b1; stall = 1'b1; q.push_back(64'h50);
    cycle();
    im_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus !== 64'h54 || im_req !== 1'b0) begin
        errors++; $display("FAIL st_hold bus=%h req=%b required=54/0", bus, im_req);
      end
      if (i < 3) cycle();
    end
    salto = 1'b1; result_suma = 64'h80;
    cycle();
    salto = 1'b0;
    checks++;
    if (bus !== 64'h80 || im_req !== 1'b0) begin
      errors++; $display("FAIL st_branch bus=%h req=%b required=80/0", bus, im_req);
    end
    stall = 1'b0;
    cycle();
    checks++;
    if (bus !== 64'h80 || im_req !== 1'b1) begin
      errors++; $display("FAIL st_resume bus=%h req=%b required=80/1", bus, im_req);
    end
    stall = 1'b1;
    repeat (2) begin
      cycle();
      checks++;
      if (bus !== 64'h80 || im_req !== 1'b1) begin
        errors++; $display("FAIL st_ignored bus=%h req=%b required=80/1", bus, im_req);
      end
    end
    im_ready = 1'b1; salto = 1'b1; result_suma = 64'h300;
    cycle();
    im_ready = 1'b0; salto = 1'b0;
    checks++;
    if (bus !== 64'h300 || im_req !== 1'b0 || instr_valida !== 1'b0) begin
      errors++;
      $display("FAIL st_salto bus=%h req=%b val=%b required=300/0/0", bus, im_req, instr_valida);
    end
    stall = 1'b0;
    cycle();
    checks++;
    if (bus !== 64'h300 || im_req !== 1'b1) begin
      errors++; $display("FAIL st_salto_resume bus=%h req=%b required=300/1", bus, im_req);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_addr [4];
    exp_addr[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_addr[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_addr[2] = 64'h0;                   exp_addr[3] = 64'h4;
    reset_n_w  = 1'b1;
    im_ready_w = 1'b1;
    checks++;
    if (bus_w !== exp_addr[0] || im_req_w !== 1'b0) begin
      errors++; $display("FAIL wrap_reset bus=%h req=%b required=%h/0", bus_w, im_req_w, exp_addr[0]);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (bus_w !== exp_addr[i] || im_req_w !== 1'b1) begin
        errors++; $display("FAIL wrap_fetch bus=%h req=%b required=%h/1", bus_w, im_req_w, exp_addr[i]);
      end
      q_w.push_back(exp_addr[i]);
    end
    cycle();
    im_ready_w = 1'b0;
    checks++;
    if (bus_w !== 64'h8) begin
      errors++; $display("FAIL wrap_after bus=%h required=8", bus_w);
    end
  endtask

  task automatic test_drain();
    repeat (3) cycle();
    checks++;
    if (q.size() != 0 || q_w.size() != 0) begin
      errors++; $display("FAIL sb_drain left=%0d/%0d required=0/0", q.size(), q_w.size());
    end
  endtask

  initial begin
    reset_n = 1'b0; reset_n_w = 1'b0;
    result_suma = '0; salto = 1'b0; stall = 1'b0;
    im_ready = 1'b0; im_ready_w = 1'b0;
    test_reset();
    test_backpressure();
    test_branch_wait();
    test_branch_transfer();
    test_stall();
    test_wrap();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
